score_digit_renderer: RTL and testbench
=======================================

Name: score_digit_renderer

Overview:
- Sits directly upstream of the digit/status glyph ROM, between the VGA timing generator and the pixel colour mux.
- Converts a binary score to BCD with a sequential shift-add-3 engine and holds the result as the displayed digits.
- For each incoming pixel coordinate, drives the ROM's glyph column, row and type inputs, then registers the returned dot as a pixel-on flag.

Parameters:
- X0, 480, left pixel column of the 4-digit field.
- Y0, 16, top pixel row of the field.
- GLYPH_W, 30, glyph width in pixels; fixed by ROM geometry.
- GLYPH_H, 40, glyph height in pixels; fixed by ROM geometry.

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_h_cnt  in  10  current pixel column
- i_v_cnt  in  10  current pixel row
- i_score  in  14  binary score, unsigned
- i_score_valid  in  1  one-cycle strobe; i_score is sampled when high
- o_busy  out  1  BCD conversion in progress
- o_x  out  5  glyph column to ROM, 0..29
- o_y  out  6  glyph row to ROM, 0..39
- o_type  out  4  glyph select to ROM, 0..9 = digit
- i_dot  in  1  ROM dot, combinational from o_x/o_y/o_type
- o_in_field  out  1  pixel lies inside a visible digit cell, 2-cycle aligned
- o_dot_on  out  1  glyph pixel lit, 2-cycle aligned

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values:
  - FSM = IDLE; o_busy = 0; pending flag = 0.
  - Displayed digits = 0,0,0,0.
  - o_x = 0, o_y = 0, o_type = 0, o_in_field = 0, o_dot_on = 0.
  - Reset mid-conversion aborts it; displayed digits return to 0.
- Saturation: sampled scores above 9999 are clamped to 9999 before conversion.
- FSM states:
  - IDLE: on valid (or pending), load value into the shift register, clear the BCD accumulator, clear pending, go to SHIFT. o_busy = 0 in IDLE only.
  - SHIFT: exactly 14 cycles. Each cycle: add 3 to any BCD nibble >= 5, then shift left 1 with the binary MSB entering. Counter 0..13, then go to COMMIT.
  - COMMIT: 1 cycle. Copy the 4 BCD nibbles into the displayed-digit registers, return to IDLE.
- Latency: valid sampled at edge N; displayed digits change at edge N+16.
- Valid while busy: the value is stored in a pending register. A later valid overwrites it (last value wins). After COMMIT, IDLE starts the pending value on the next edge.
- Valid in the same cycle as COMMIT: treated as pending.
- Render pipeline stage 1 (registered):
  - Field = X0 <= h < X0+120 and Y0 <= v < Y0+40.
  - Digit index k = 0..3, left to right (thousands first), chosen by comparing h against X0+30k boundaries; no divider.
  - o_x = h - X0 - 30k; o_y = v - Y0; o_type = displayed digit k.
  - Leading-zero blank: digit k is invisible if k<3 and digits 0..k are all zero. The ones digit is always visible.
  - in_field_s1 = field and visible.
  - Outside the field: o_x/o_y/o_type hold 0.
- Render pipeline stage 2: o_in_field <= in_field_s1; o_dot_on <= in_field_s1 and i_dot.
- Display update: digit registers may change mid-frame. The pipeline always uses the current registers; tearing is acceptable.

Test Plan:
- Reset asserted mid-SHIFT -> o_busy = 0, displayed digits 0000, o_dot_on = 0 on the next cycle; no commit occurs after release.
- i_score = 1234 pulse -> o_busy high for 16 cycles; digits = 1,2,3,4 exactly 16 edges after the strobe edge.
- i_score = 16383 -> displays 9999. i_score = 0 -> only the ones cell is visible, digit 0.
- Valid 57 during busy, then valid 89 two cycles later -> first value commits, then 89 converts. Final digits 0,0,8,9; the 57 value never appears.
- Pixel sweep at v = Y0+5 with score 7 -> o_in_field is high only for h in [X0+90, X0+119], 2 cycles delayed. At h = X0+95: o_x = 5, o_y = 5, o_type = 7.
- ROM stub returns i_dot = 1 -> o_dot_on equals o_in_field. h = X0+119 gives o_x = 29; h = X0+120 gives o_in_field = 0.

Source files
------------

// File: rtl/score_digit_renderer.sv
// Score-to-BCD converter (sequential shift-add-3) and 4-digit glyph addresser
// feeding the digit ROM, with a two-stage registered pixel-on output.
module score_digit_renderer #(
  parameter int unsigned X0      = 480,
  parameter int unsigned Y0      = 16,
  parameter int unsigned GLYPH_W = 30,
  parameter int unsigned GLYPH_H = 40
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [9:0]  i_h_cnt,
  input  logic [9:0]  i_v_cnt,
  input  logic [13:0] i_score,
  input  logic        i_score_valid,
  output logic        o_busy,
  output logic [4:0]  o_x,
  output logic [5:0]  o_y,
  output logic [3:0]  o_type,
  input  logic        i_dot,
  output logic        o_in_field,
  output logic        o_dot_on
);
  // state  | meaning
  // IDLE   | waiting for a new or pending score
  // SHIFT  | 14 add-3/shift steps over the binary value
  // COMMIT | copy BCD result into the displayed digits
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  localparam logic [9:0] FX0 = 10'(X0);
  localparam logic [9:0] FX1 = 10'(X0 + GLYPH_W);
  localparam logic [9:0] FX2 = 10'(X0 + 2 * GLYPH_W);
  localparam logic [9:0] FX3 = 10'(X0 + 3 * GLYPH_W);
  localparam logic [9:0] FX4 = 10'(X0 + 4 * GLYPH_W);
  localparam logic [9:0] FY0 = 10'(Y0);
  localparam logic [9:0] FY1 = 10'(Y0 + GLYPH_H);

  state_t      state;
  logic [3:0]  cnt;
  logic [29:0] work;       // {bcd[15:0], binary[13:0]}
  logic [29:0] work_adj;
  logic [13:0] pend_val;
  logic [13:0] score_sat;
  logic        pending;
  logic [15:0] digits;     // thousands in [15:12]

  assign score_sat = (i_score > 14'd9999) ? 14'd9999 : i_score;

  always_comb begin
    work_adj = work;
    for (int n = 0; n < 4; n++) begin
      if (work[14+4*n +: 4] >= 4'd5)
        work_adj[14+4*n +: 4] = work[14+4*n +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      pend_val <= '0;
      pending  <= 1'b0;
      digits   <= '0;
      o_busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_busy <= pending | i_score_valid;
          if (pending) begin
            work    <= {16'd0, pend_val};
            cnt     <= '0;
            pending <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          o_busy <= 1'b1;
          work   <= work_adj << 1;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd13) state <= COMMIT;
        end
        COMMIT: begin
          o_busy <= pending | i_score_valid;
          digits <= work[29:14];
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Every strobe goes through the pending slot; last value wins.
      if (i_score_valid) begin
        pend_val <= score_sat;
        pending  <= 1'b1;
      end
    end
  end

  logic       field;
  logic       visible;
  logic       in_field_s1;
  logic [1:0] k;
  logic [4:0] x_base;
  logic [3:0] dig;

  always_comb begin
    field = (i_h_cnt >= FX0) && (i_h_cnt < FX4) && (i_v_cnt >= FY0) && (i_v_cnt < FY1);
    if (i_h_cnt < FX1)      begin k = 2'd0; x_base = FX0[4:0]; end
    else if (i_h_cnt < FX2) begin k = 2'd1; x_base = FX1[4:0]; end
    else if (i_h_cnt < FX3) begin k = 2'd2; x_base = FX2[4:0]; end
    else                    begin k = 2'd3; x_base = FX3[4:0]; end
    case (k)
      2'd0:    begin dig = digits[15:12]; visible = digits[15:12] != 4'd0; end
      2'd1:    begin dig = digits[11:8];  visible = digits[15:8]  != 8'd0; end
      2'd2:    begin dig = digits[7:4];   visible = digits[15:4]  != 12'd0; end
      default: begin dig = digits[3:0];   visible = 1'b1; end
    endcase
  end

  // Offsets fit in the low bits, so subtract on truncated operands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_x         <= '0;
      o_y         <= '0;
      o_type      <= '0;
      in_field_s1 <= 1'b0;
      o_in_field  <= 1'b0;
      o_dot_on    <= 1'b0;
    end else begin
      if (field) begin
        o_x    <= i_h_cnt[4:0] - x_base;
        o_y    <= i_v_cnt[5:0] - FY0[5:0];
        o_type <= dig;
      end else begin
        o_x    <= '0;
        o_y    <= '0;
        o_type <= '0;
      end
      in_field_s1 <= field & visible;
      o_in_field  <= in_field_s1;
      o_dot_on    <= in_field_s1 & i_dot;
    end
  end
endmodule

// File: tb/tb_score_digit_renderer.sv
// Bench for score_digit_renderer: score table, pixel scoreboard with a
// division-based glyph model, and hand sequences for timing/pending/reset.
module tb_score_digit_renderer;
  localparam int X0 = 480;
  localparam int Y0 = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic [13:0] score = '0;
  logic        score_valid = 1'b0;
  logic        busy;
  logic [4:0]  x;
  logic [5:0]  y;
  logic [3:0]  gtype;
  logic        dot;
  logic        in_field;
  logic        dot_on;
  logic        dot_all = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {int h; int v; int x; int y; int typ; bit fld; bit dot;} pix_t;
  typedef struct {int score; int disp;} vec_t;

  pix_t q_drive[$];
  pix_t q_s1[$];
  pix_t q_s2[$];

  score_digit_renderer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_h_cnt(h_cnt), .i_v_cnt(v_cnt),
    .i_score(score), .i_score_valid(score_valid), .o_busy(busy),
    .o_x(x), .o_y(y), .o_type(gtype), .i_dot(dot),
    .o_in_field(in_field), .o_dot_on(dot_on)
  );

  // ROM stub: either solid or a checker pattern of the glyph coordinates.
  assign dot = dot_all ? 1'b1 : (x[0] ^ y[1]);

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic pix_t model(input int h, input int v, input int disp);
    pix_t p;
    int d[4];
    int kk;
    d[0] = disp / 1000; d[1] = (disp / 100) % 10; d[2] = (disp / 10) % 10; d[3] = disp % 10;
    p.h = h; p.v = v; p.x = 0; p.y = 0; p.typ = 0; p.fld = 0; p.dot = 0;
    if (h >= X0 && h < X0 + 120 && v >= Y0 && v < Y0 + 40) begin
      kk = (h - X0) / 30;
      p.x = (h - X0) % 30;
      p.y = v - Y0;
      p.typ = d[kk];
      p.fld = (kk == 3);
      for (int j = 0; j <= kk; j++) if (d[j] != 0) p.fld = 1;
      p.dot = p.fld && (dot_all || ((p.x % 2) != ((p.y / 2) % 2)));
    end
    return p;
  endfunction

  task automatic push_px(input int h, input int v, input int disp);
    q_drive.push_back(model(h, v, disp));
  endtask

  // Streams queued pixels one per cycle; outputs are popped as each stage produces them.
  task automatic run_stream();
    pix_t p;
    while (q_drive.size() > 0 || q_s1.size() > 0 || q_s2.size() > 0) begin
      @(negedge clk);
      if (q_s2.size() > 0) begin
        p = q_s2.pop_front();
        chk($sformatf("in_field h=%0d v=%0d", p.h, p.v), int'(in_field), int'(p.fld));
        chk($sformatf("dot_on h=%0d v=%0d", p.h, p.v), int'(dot_on), int'(p.dot));
      end
      if (q_s1.size() > 0) begin
        p = q_s1.pop_front();
        chk($sformatf("o_x h=%0d v=%0d", p.h, p.v), int'(x), p.x);
        chk($sformatf("o_y h=%0d v=%0d", p.h, p.v), int'(y), p.y);
        chk($sformatf("o_type h=%0d v=%0d", p.h, p.v), int'(gtype), p.typ);
        q_s2.push_back(p);
      end
      if (q_drive.size() > 0) begin
        p = q_drive.pop_front();
        h_cnt = 10'(p.h);
        v_cnt = 10'(p.v);
        q_s1.push_back(p);
      end
    end
  endtask

  task automatic check_digits(input int disp);
    for (int kk = 0; kk < 4; kk++) push_px(X0 + 30 * kk + 3, Y0 + 2, disp);
    run_stream();
  endtask

  task automatic pulse(input int s);
    @(negedge clk);
    score = 14'(s);
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, " busy timeout"}, 1, 0);
  endtask

  initial begin
    vec_t tbl[8];
    int sevens;
    tbl[0] = '{1234, 1234};
    tbl[1] = '{16383, 9999};
    tbl[2] = '{0, 0};
    tbl[3] = '{7, 7};
    tbl[4] = '{10000, 9999};
    tbl[5] = '{100, 100};
    tbl[6] = '{9999, 9999};
    tbl[7] = '{1005, 1005};

    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset o_x", int'(x), 0);
    chk("reset o_y", int'(y), 0);
    chk("reset o_type", int'(gtype), 0);
    chk("reset in_field", int'(in_field), 0);
    chk("reset dot_on", int'(dot_on), 0);
    rst_n = 1'b1;
    check_digits(0);

    // Latency: busy for 16 cycles, ones glyph switches to 4 one cycle after the commit edge.
    h_cnt = 10'(X0 + 91);
    v_cnt = 10'(Y0 + 1);
    @(negedge clk);
    score = 14'd1234;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    for (int j = 0; j < 20; j++) begin
      chk($sformatf("latency busy j=%0d", j), int'(busy), (j <= 15) ? 1 : 0);
      chk($sformatf("latency ones j=%0d", j), int'(gtype), (j >= 17) ? 4 : 0);
      @(negedge clk);
    end

    for (int i = 0; i < 8; i++) begin
      pulse(tbl[i].score);
      wait_idle($sformatf("table %0d", i));
      check_digits(tbl[i].disp);
    end

    // Pending: 57 and 89 arrive during a conversion; only 89 follows it.
    pulse(1234);
    pulse(57);
    @(negedge clk);
    pulse(89);
    h_cnt = 10'(X0 + 91);
    v_cnt = 10'(Y0 + 1);
    sevens = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (gtype == 4'd7) sevens++;
    end
    chk("pending 57 never shown", sevens, 0);
    chk("pending busy done", int'(busy), 0);
    check_digits(89);

    // Sweeps with score 7: patterned dot, then solid dot.
    pulse(7);
    wait_idle("sweep");
    for (int h = X0 - 3; h < X0 + 125; h++) push_px(h, Y0 + 5, 7);
    run_stream();
    dot_all = 1'b1;
    for (int h = X0 + 85; h < X0 + 125; h++) push_px(h, Y0 + 5, 7);
    for (int v = Y0 - 2; v < Y0 + 43; v++) push_px(X0 + 95, v, 7);
    run_stream();
    dot_all = 1'b0;

    // Reset in the middle of SHIFT aborts and clears everything.
    pulse(4321);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid reset busy", int'(busy), 0);
    chk("mid reset dot_on", int'(dot_on), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("post reset busy", int'(busy), 0);
    check_digits(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
